// File: rtl/keypad_pkg.sv
// keypad_pkg: shared geometry, column reset pattern and key map for the 4x4 keypad scanner
package keypad_pkg;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam logic [COLS-1:0] COL_RESET = 4'b1110;
  // nibble i is the hex code of snapshot bit i = 4*col + row
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a sweep word once it repeats for DEBOUNCE_SCANS consecutive sweeps
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ROWS*COLS-1:0] word,
  input  logic                 sweep_end,
  output logic [ROWS*COLS-1:0] stable
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [ROWS*COLS-1:0] cand;
  logic [CW-1:0] cnt;
  logic same, accept;
  always_comb begin
    same = word == cand;
    accept = same ? cnt == CW'(DEBOUNCE_SCANS - 1) : DEBOUNCE_SCANS == 1;
  end
  always_ff @(posedge Clk)
    if (!Reset) begin
      cand <= '0;
      cnt <= '0;
      stable <= '0;
    end else if (sweep_end) begin
      cand <= word;
      cnt <= !same ? CW'(1) : (cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + 1'b1);
      if (accept) stable <= word;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-multiplexed 4x4 keypad scan with debounce and single-key decode
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [ROWS-1:0] Row,
  output logic [COLS-1:0] Col,
  output logic [3:0]      KeyCode,
  output logic            KeyValid,
  output logic            KeyHeld
);
  localparam int W = ROWS * COLS;
  localparam int DW = $clog2(SCAN_DIV);
  logic [ROWS-1:0] row_meta, row_sync;
  logic [DW-1:0] div;
  logic [1:0] col_idx;
  logic [W-ROWS-1:0] snap;
  logic [W-1:0] sweep, stable, stable_q;
  logic tick, sweep_end, single;
  logic [3:0] idx;
  always_comb begin
    tick = div == DW'(SCAN_DIV - 1);
    sweep_end = tick && col_idx == 2'd3;
    sweep = {~row_sync, snap};
    single = stable != '0 && (stable & (stable - 1'b1)) == '0;
    idx = '0;
    for (int i = 0; i < W; i++) if (stable[i]) idx = 4'(i);
  end
  // snap shifts in one column per tick so columns 0..2 sit in order when column 3 is sampled
  always_ff @(posedge Clk)
    if (!Reset) begin
      row_meta <= '1;
      row_sync <= '1;
      div <= '0;
      col_idx <= '0;
      Col <= COL_RESET;
      snap <= '0;
      stable_q <= '0;
      KeyCode <= '0;
      KeyValid <= 1'b0;
      KeyHeld <= 1'b0;
    end else begin
      row_meta <= Row;
      row_sync <= row_meta;
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        snap <= {~row_sync, snap[W-ROWS-1:ROWS]};
        col_idx <= col_idx + 1'b1;
        Col <= {Col[COLS-2:0], Col[COLS-1]};
      end
      stable_q <= stable;
      KeyHeld <= single;
      KeyValid <= single && stable != stable_q;
      if (single) KeyCode <= key_code(idx);
    end
  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .Clk(Clk),
    .Reset(Reset),
    .word(sweep),
    .sweep_end(sweep_end),
    .stable(stable)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model, key-table vectors, corner sequences and random sweeps vs a run-length model
module tb_keypad_scanner;
  localparam int SD = 8;
  localparam int DS = 2;
  localparam int SW = 4 * SD;
  localparam int LAT = (DS + 1) * SW + 4;
  typedef struct {
    int r;
    int c;
    logic [3:0] code;
  } vec_t;
  logic Clk = 1'b0, Reset = 1'b0;
  logic [3:0] Row, Col, KeyCode;
  logic KeyValid, KeyHeld;
  logic [15:0] keys = '0;
  int total = 0, bad = 0, pulses = 0, cyc = 0, p0 = 0;
  logic last_valid = 1'b0;
  logic [3:0] e;
  vec_t tbl[16];
  logic [15:0] hist[$];
  logic [15:0] kset, st_m;
  logic [3:0] code_m;
  int exp_p, len, kind, ka, kb, k;
  bit all_eq, fresh;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .Clk(Clk), .Reset(Reset), .Row(Row), .Col(Col),
    .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
  );

  always #5 Clk = ~Clk;

  // keys bit r*4+c pulls row r low while column c is driven low
  always_comb for (int r = 0; r < 4; r++) Row[r] = ~|(keys[r*4 +: 4] & ~Col);

  always @(posedge Clk) cyc <= Reset ? cyc + 1 : 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (KeyValid) begin
      pulses++;
      chk("valid_width", int'(last_valid), 0);
    end
    last_valid = KeyValid;
  end

  function automatic logic [3:0] kmap(input int i);
    logic [63:0] t;
    t = 64'h123A456B789C0FED;
    return t[63-4*i -: 4];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge Clk) Reset = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
  endtask

  task automatic align;
    while (cyc % SW != 2) tick(1);
  endtask

  task automatic wait_pulse(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      tick(1);
      got = KeyValid;
    end
    chk(name, int'(got), 1);
  endtask

  task automatic wait_release(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      tick(1);
      got = !KeyHeld;
    end
    chk(name, int'(got), 1);
  endtask

  task automatic chk_reset_vals;
    chk("rst_col", int'(Col), 'hE);
    chk("rst_code", int'(KeyCode), 0);
    chk("rst_valid", int'(KeyValid), 0);
    chk("rst_held", int'(KeyHeld), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{'{0, 0, 4'h1}, '{0, 1, 4'h2}, '{0, 2, 4'h3}, '{0, 3, 4'hA},
            '{1, 0, 4'h4}, '{1, 1, 4'h5}, '{1, 2, 4'h6}, '{1, 3, 4'hB},
            '{2, 0, 4'h7}, '{2, 1, 4'h8}, '{2, 2, 4'h9}, '{2, 3, 4'hC},
            '{3, 0, 4'h0}, '{3, 1, 4'hF}, '{3, 2, 4'hE}, '{3, 3, 4'hD}};
    do_reset;
    chk_reset_vals;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      e = ~(4'b0001 << (((i + 1) / 8) % 4));
      chk("col_rot", int'(Col), int'(e));
    end
    align;
    p0 = pulses;
    keys[1*4+1] = 1'b1;
    wait_pulse("press5_pulse", LAT);
    chk("press5_code", int'(KeyCode), 'h5);
    chk("press5_held", int'(KeyHeld), 1);
    tick(10 * SW);
    chk("hold_pulses", pulses - p0, 1);
    chk("hold_held", int'(KeyHeld), 1);
    p0 = pulses;
    keys = '0;
    wait_release("release5", LAT);
    tick(2 * SW);
    chk("release5_code", int'(KeyCode), 'h5);
    chk("release5_pulses", pulses - p0, 0);
    p0 = pulses;
    keys[3*4+2] = 1'b1;
    wait_pulse("pressE_pulse", LAT);
    chk("pressE_code", int'(KeyCode), 'hE);
    tick(3 * SW);
    chk("pressE_pulses", pulses - p0, 1);
    keys = '0;
    wait_release("releaseE", LAT);
    tick(2 * SW);
    align;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      keys[0*4+3] = (i % 2 == 0);
      tick(SW);
    end
    chk("bounce_pulses", pulses - p0, 0);
    keys[0*4+3] = 1'b1;
    wait_pulse("bounceA_pulse", LAT);
    chk("bounceA_code", int'(KeyCode), 'hA);
    tick(2 * SW);
    chk("bounceA_pulses", pulses - p0, 1);
    keys = '0;
    wait_release("releaseA", LAT);
    tick(2 * SW);
    align;
    p0 = pulses;
    keys[0*4+0] = 1'b1;
    keys[2*4+2] = 1'b1;
    tick(4 * SW);
    chk("chord_pulses", pulses - p0, 0);
    chk("chord_held", int'(KeyHeld), 0);
    chk("chord_code", int'(KeyCode), 'hA);
    keys[2*4+2] = 1'b0;
    wait_pulse("chord_to_1_pulse", LAT);
    chk("chord_to_1_code", int'(KeyCode), 'h1);
    chk("chord_to_1_held", int'(KeyHeld), 1);
    keys = '0;
    wait_release("release1", LAT);
    tick(2 * SW);
    align;
    keys[2*4+0] = 1'b1;
    tick(SW);
    p0 = pulses;
    do_reset;
    chk_reset_vals;
    chk("mid_reset_pulses", pulses - p0, 0);
    wait_pulse("post_reset_pulse", LAT);
    chk("post_reset_code", int'(KeyCode), 'h7);
    tick(2 * SW);
    chk("post_reset_pulses", pulses - p0, 1);
    for (int i = 0; i < 16; i++) begin
      keys = '0;
      wait_release("tbl_release", LAT);
      tick(SW);
      p0 = pulses;
      keys[tbl[i].r*4+tbl[i].c] = 1'b1;
      wait_pulse("tbl_pulse", LAT);
      chk("tbl_code", int'(KeyCode), int'(tbl[i].code));
      chk("tbl_held", int'(KeyHeld), 1);
      tick(SW);
      chk("tbl_pulses", pulses - p0, 1);
    end
    keys = '0;
    do_reset;
    align;
    hist.delete();
    st_m = '0;
    code_m = '0;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      ka = int'($urandom_range(0, 15));
      kb = int'($urandom_range(0, 15));
      kset = '0;
      if (kind != 0) kset[ka] = 1'b1;
      if (kind == 3) kset[kb] = 1'b1;
      len = int'($urandom_range(1, 3));
      p0 = pulses;
      exp_p = 0;
      keys = kset;
      for (int s = 0; s < len; s++) begin
        hist.push_back(kset);
        k = hist.size() - 1;
        if (k + 1 >= DS) begin
          all_eq = 1;
          for (int j = 0; j < DS; j++) if (hist[k-j] != hist[k]) all_eq = 0;
          fresh = (k + 1 == DS) || hist[k-DS] != hist[k];
          if (all_eq && fresh) begin
            if ($countones(hist[k]) == 1 && hist[k] != st_m) begin
              exp_p++;
              for (int b = 0; b < 16; b++) if (hist[k][b]) code_m = kmap(b);
            end
            st_m = hist[k];
          end
        end
      end
      tick(len * SW);
      chk("rnd_pulses", pulses - p0, exp_p);
      chk("rnd_held", int'(KeyHeld), int'($countones(st_m) == 1));
      chk("rnd_code", int'(KeyCode), int'(code_m));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path: where the display scanner drives digits one at a time, this block drives 4x4 keypad columns one at a time and reads back the row lines.
- Target is the Basys3 Pmod KYPD.
- Produces a debounced 4-bit hex key code plus a one-cycle event strobe. The code feeds the display path; for example, it can replace SW[3:0] as a digit data source.

Parameters:
- SCAN_DIV, 100000, clock cycles each column is driven before its rows are sampled (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full sweeps required before a snapshot is accepted as stable; minimum 1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Row  input  4  keypad row lines, active-low (pulled up), asynchronous to Clk.
- Col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- KeyCode  output  4  hex code of the last accepted key; holds its value after release.
- KeyValid  output  1  one-cycle pulse when a new single key is accepted.
- KeyHeld  output  1  high while the stable snapshot contains exactly one pressed key.

Behaviour:
- Clock and reset: single clock domain. Reset is sampled on the Clk edge while low.
- Reset values: Col=4'b1110, KeyCode=4'h0, KeyValid=0, KeyHeld=0. Divider, column index, snapshot, candidate, debounce count and stable snapshot are all cleared.
- Reset mid-sweep: the sweep is abandoned, with no partial result and no KeyValid.
- Row synchronizer: two-flop synchronizer on Row. Synchronizer flops reset to 4'b1111.
- Column timing:
  - Divider counts 0..SCAN_DIV-1 while column c is driven low.
  - At count SCAN_DIV-1, the synchronized rows are inverted and captured into snapshot bits [4c+3:4c], where bit 4c+r = key (row r, col c) pressed.
  - On that same cycle, c advances by (c+1) mod 4, Col rotates, and the divider wraps to 0.
  - Col change and divider wrap occur on the same edge.
- Sweep end: the edge capturing column 3 completes a 16-bit sweep word S.
- Debounce, evaluated on each sweep end:
  - If S == candidate, the count saturates at DEBOUNCE_SCANS.
  - Otherwise candidate=S and count=1.
  - When the count reaches DEBOUNCE_SCANS (the transition into that value, or the first sweep when DEBOUNCE_SCANS=1), stable takes S.
- Decode of stable, updated one cycle after stable changes:
  - Popcount 0: KeyHeld=0, KeyCode unchanged.
  - Popcount 1: KeyHeld=1, KeyCode=map(index).
  - Popcount >=2 (ghosting or chord): KeyHeld=0, KeyCode unchanged, no KeyValid.
- KeyValid rule: a single-cycle pulse, coincident with the KeyCode update, when stable transitions to popcount 1 from any different value, i.e. a new press or a direct switch to a different single key. Holding a key produces exactly one pulse.
- Key map, indexed by row r (0..3), then columns 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Latency: a press held steadily is accepted within (DEBOUNCE_SCANS+1) sweeps + 4 cycles, where one sweep = 4*SCAN_DIV cycles. A release has the same latency.
- Bounce: any row glitch that alters a sweep word resets the count to 1, so no event is produced until the input has been quiet for DEBOUNCE_SCANS sweeps.

Decomposition:
- Shared package keypad_pkg, holding:
  - the 16-entry key-map constant (index -> hex code);
  - the COLS/ROWS=4 constants;
  - the Col reset pattern 4'b1110.
- One sub-module, keypad_debounce: sweep word in, sweep-end strobe in, stable word out. It contains the candidate/count logic.
- Column rotation, divider, synchronizer and decode stay in keypad_scanner.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=2, so one sweep = 32 cycles; the bench models the keypad by pulling Row[r] low when Col[c] is low and key (r,c) is held):
- Reset low 3 cycles, then high -> Col=1110 and KeyValid/KeyHeld/KeyCode=0. Col steps 1110->1101->1011->0111->1110, each held 8 cycles, 32-cycle period.
- Hold key (r1,c1) from cycle 40 -> exactly one KeyValid pulse with KeyCode=4'h5 within 3 sweeps + 4 cycles. KeyHeld=1 while held; no further pulses over 10 sweeps.
- Release -> KeyHeld=0 within 3 sweeps + 4 cycles. KeyCode stays 4'h5 and no KeyValid fires. Then press (r3,c2) -> KeyCode=4'hE with one pulse.
- Bounce key (r0,c3) by toggling every 20 cycles for 5 sweeps, then hold -> no KeyValid during bounce, then a single pulse with KeyCode=4'hA.
- Hold (r0,c0) and (r2,c2) simultaneously -> no KeyValid and KeyHeld=0. Releasing (r2,c2) -> pulse with KeyCode=4'h1.
- Assert Reset mid-debounce (after the first qualifying sweep) -> outputs return to reset values and no pulse occurs. The key still held after reset is accepted afresh with one pulse.
